// File: rtl/count8_sched.sv
`default_nettype none
// ============================================================================
// Module      : count8_sched
// Description : Round-robin sequencer that shares one external up-counter
//               between two requesters. The winner's interval length is
//               latched at grant. The FSM loads the counter to zero, enables
//               it up to the latched length, then pulses done for the winner.
//               Dropping the granted request during LOAD/RUN aborts the
//               interval without a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module count8_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             cnt_load,
    output logic             cnt_en,
    output logic [WIDTH-1:0] cnt_d,
    input  logic [WIDTH-1:0] cnt_q
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_gnt;
    logic [WIDTH-1:0] r_len;
    logic             r_ptr;

    logic             w_win;
    logic             w_hold;
    logic             w_term;

    // Arbitration: on a tie the round-robin pointer picks, otherwise the
    // single active requester wins. w_win is the index of the winner.
    always_comb begin
        w_win = 1'b0;
        if (req == 2'b11) begin
            w_win = r_ptr;
        end else begin
            w_win = req[1];
        end
    end

    // Granted requester still holding its request, and terminal-count compare
    // against the latched length.
    always_comb begin
        w_hold = |(req & r_gnt);
        w_term = (cnt_q == r_len);
    end

    // Sequencer state, grant, latched length and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_gnt   <= 2'b00;
            r_len   <= '0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req != 2'b00) begin
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_len   <= w_win ? len1 : len0;
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (!w_hold) begin
                        // Abort: the other requester gets priority next.
                        r_gnt   <= 2'b00;
                        r_ptr   <= r_gnt[0];
                        r_state <= c_IDLE;
                    end else begin
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (!w_hold) begin
                        r_gnt   <= 2'b00;
                        r_ptr   <= r_gnt[0];
                        r_state <= c_IDLE;
                    end else if (w_term) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    // DONE always returns to IDLE, forcing an idle gap.
                    r_gnt   <= 2'b00;
                    r_ptr   <= r_gnt[0];
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Output decode. Everything except cnt_en comes from registered state;
    // cnt_en must react to cnt_q in the same cycle so the counter stops
    // exactly on the latched length and never wraps.
    always_comb begin
        gnt      = r_gnt;
        done     = (r_state == c_DONE) ? r_gnt : 2'b00;
        busy     = (r_state != c_IDLE);
        cnt_load = (r_state == c_LOAD);
        cnt_d    = '0;
        cnt_en   = (r_state == c_RUN) && w_hold && !w_term;
    end

endmodule
`default_nettype wire
